// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor front end.
// Provides the fetch FSM state type and default widths/addresses
// used by ins_fetch and its PC register.
package simple_processor_pkg;

    // Width of one instruction word delivered by IMEM.
    localparam int INSTR_WIDTH = 32;

    // Default IMEM word-address width (PC is word-addressed).
    localparam int ADDR_WIDTH_DEF = 8;

    // Default PC value after reset and after an invalid instruction.
    localparam logic [ADDR_WIDTH_DEF-1:0] BOOT_ADDR_DEF = '0;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

endpackage : simple_processor_pkg

// File: rtl/ins_fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Boot-load has priority over increment; increment wraps modulo
// 2^ADDR_WIDTH so the all-ones address is followed by 0.
module pc_reg
    import simple_processor_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_incr,
    input  logic                  i_load_boot,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    logic [ADDR_WIDTH-1:0] r_pc;

    // PC update: reboot target wins over advance, otherwise hold.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_pc <= BOOT_ADDR;
        end else if (i_load_boot) begin
            r_pc <= BOOT_ADDR;
        end else if (i_incr) begin
            r_pc <= r_pc + ADDR_WIDTH'(1);
        end
    end

    assign o_pc = r_pc;

endmodule : pc_reg

// File: rtl/ins_fetch.sv
// Instruction fetch stage feeding the decoder.
// Issues one outstanding IMEM read at a time, captures the returned word
// and offers it downstream with valid/ready. The decoder's valid_pc verdict
// at accept selects PC+1 or the boot address for the next fetch.
//
// Handshake: instr_o is transferred on a rising edge where
// instr_valid_o=1 and instr_ready_i=1; while valid is high and ready is
// low, instr_o and instr_valid_o hold. IMEM side: imem_req_o stays high
// until a cycle with imem_ack_i=1, whose rdata is captured on that edge.
//
// Optional build macro: INS_FETCH_TIMEOUT_EN adds a request watchdog that
// reboots the PC and pulses fetch_err_o after TIMEOUT_CYCLES unacked
// request cycles. Without it fetch_err_o is constant 0.
//
// All outputs come from registers or from the state register alone.
module ins_fetch
    import simple_processor_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR      = ADDR_WIDTH'(BOOT_ADDR_DEF)
`ifdef INS_FETCH_TIMEOUT_EN
    ,
    parameter int                    TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   imem_ack_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    input  logic                   valid_pc_i,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   fetch_err_o,
    output fetch_state_t           dbg_state_o
);

    fetch_state_t           r_state;
    fetch_state_t           w_state_nxt;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  w_pc;
    logic                   w_ack_in_req;
    logic                   w_accept;
    logic                   w_timeout;
    logic                   w_pc_incr;
    logic                   w_pc_boot;

    // An ack only counts while a request is outstanding.
    assign w_ack_in_req = (r_state == S_REQ) && imem_ack_i;
    // Downstream takes the held instruction.
    assign w_accept     = (r_state == S_VALID) && instr_ready_i;

`ifdef INS_FETCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_fetch_err;

    // Fires on the edge closing the TIMEOUT_CYCLES-th unacked request
    // cycle; an ack in that same cycle takes precedence.
    assign w_timeout = (r_state == S_REQ) && !imem_ack_i &&
                       (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Count unacked request cycles; clear on ack, timeout or leaving S_REQ.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wait_cnt <= '0;
        end else if ((r_state != S_REQ) || imem_ack_i || w_timeout) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // One-cycle error pulse following a timeout.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_fetch_err <= 1'b0;
        end else begin
            r_fetch_err <= w_timeout;
        end
    end

    assign fetch_err_o = r_fetch_err;
`else
    assign w_timeout   = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    // Advance on a good verdict, reboot on a bad one or on a timeout.
    assign w_pc_incr = w_accept && valid_pc_i;
    assign w_pc_boot = (w_accept && !valid_pc_i) || w_timeout;

    pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BOOT_ADDR  (BOOT_ADDR)
    ) u_pc_reg (
        .i_clk       (clk_i),
        .i_arst_n    (arst_ni),
        .i_incr      (w_pc_incr),
        .i_load_boot (w_pc_boot),
        .o_pc        (w_pc)
    );

    // State register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a timeout keeps the FSM in S_REQ.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_REQ;
            S_REQ:   if (w_ack_in_req) w_state_nxt = S_VALID;
            S_VALID: if (instr_ready_i) w_state_nxt = S_REQ;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state only.
    always_comb begin
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        case (r_state)
            S_REQ:   imem_req_o    = 1'b1;
            S_VALID: instr_valid_o = 1'b1;
            default: begin
                imem_req_o    = 1'b0;
                instr_valid_o = 1'b0;
            end
        endcase
    end

    // Capture the IMEM word on the ack edge; hold it otherwise.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_instr <= '0;
        end else if (w_ack_in_req) begin
            r_instr <= imem_rdata_i;
        end
    end

    assign instr_o     = r_instr;
    assign imem_addr_o = w_pc;
    assign pc_o        = w_pc;
    assign dbg_state_o = r_state;

endmodule : ins_fetch

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: IMEM contents and a model PC are kept
// here, and every fetch is checked cycle by cycle against them.
module tb_ins_fetch;
    import simple_processor_pkg::*;

    localparam int              AW   = 8;
    localparam logic [AW-1:0]   BOOT = 8'hF0;

    logic                   clk_i;
    logic                   arst_ni;
    logic                   imem_req_o;
    logic [AW-1:0]          imem_addr_o;
    logic [INSTR_WIDTH-1:0] imem_rdata_i;
    logic                   imem_ack_i;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic                   instr_valid_o;
    logic                   instr_ready_i;
    logic                   valid_pc_i;
    logic [AW-1:0]          pc_o;
    logic                   fetch_err_o;
    fetch_state_t           dbg_state_o;

    logic [INSTR_WIDTH-1:0] mem [256];
    logic [INSTR_WIDTH-1:0] exp_q [$];
    logic [AW-1:0]          exp_pc;
    int                     chk_cnt;
    int                     pass_cnt;

`ifdef INS_FETCH_TIMEOUT_EN
    ins_fetch #(.ADDR_WIDTH(AW), .BOOT_ADDR(BOOT), .TIMEOUT_CYCLES(4)) dut (
`else
    ins_fetch #(.ADDR_WIDTH(AW), .BOOT_ADDR(BOOT)) dut (
`endif
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .imem_ack_i    (imem_ack_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .valid_pc_i    (valid_pc_i),
        .pc_o          (pc_o),
        .fetch_err_o   (fetch_err_o),
        .dbg_state_o   (dbg_state_o)
    );

    // Clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // One complete fetch, starting at a negedge with the DUT in S_REQ.
    // ws = wait states before ack, stall = cycles of ready low in S_VALID,
    // vpc = decoder verdict at accept, err0 = expected fetch_err_o in the
    // first request cycle.
    task automatic do_fetch(input int ws, input int stall, input bit vpc, input bit err0);
        logic [INSTR_WIDTH-1:0] exp_w;
        for (int i = 0; i <= ws; i++) begin
            chk_cnt++;
            if ({imem_req_o, instr_valid_o, fetch_err_o, imem_addr_o} !==
                {1'b1, 1'b0, (i == 0) ? err0 : 1'b0, exp_pc}) begin
                $display("FAIL req_phase: got req=%0b valid=%0b err=%0b addr=%02h, expected req=1 valid=0 err=%0b addr=%02h",
                         imem_req_o, instr_valid_o, fetch_err_o, imem_addr_o,
                         (i == 0) ? err0 : 1'b0, exp_pc);
            end else pass_cnt++;
            imem_ack_i   = (i == ws);
            imem_rdata_i = (i == ws) ? mem[exp_pc] : $urandom();
            if (i == ws) exp_q.push_back(mem[exp_pc]);
            @(negedge clk_i);
        end
        imem_ack_i = 1'b0;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int s = 0; s <= stall; s++) begin
            chk_cnt++;
            if ({imem_req_o, instr_valid_o, fetch_err_o, pc_o, instr_o} !==
                {1'b0, 1'b1, 1'b0, exp_pc, exp_w}) begin
                $display("FAIL valid_phase: got req=%0b valid=%0b err=%0b pc=%02h instr=%08h, expected req=0 valid=1 err=0 pc=%02h instr=%08h",
                         imem_req_o, instr_valid_o, fetch_err_o, pc_o, instr_o, exp_pc, exp_w);
            end else pass_cnt++;
            instr_ready_i = (s == stall);
            valid_pc_i    = (s == stall) ? vpc : 1'($urandom());
            imem_ack_i    = 1'($urandom());
            imem_rdata_i  = $urandom();
            @(negedge clk_i);
        end
        instr_ready_i = 1'b0;
        imem_ack_i    = 1'b0;
        exp_pc = vpc ? exp_pc + 8'd1 : BOOT;
    endtask

    // Advance the model PC to target with good verdicts.
    task automatic walk_to(input logic [AW-1:0] target);
        for (int n = 0; n < 256 && exp_pc != target; n++)
            do_fetch($urandom_range(0, 2), $urandom_range(0, 1), 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        arst_ni = 1'b0;
        instr_ready_i = 1'b0;
        valid_pc_i = 1'b0;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk_i);
        chk_cnt++;
        if ({imem_req_o, instr_valid_o, fetch_err_o, pc_o, instr_o, dbg_state_o} !==
            {1'b0, 1'b0, 1'b0, BOOT, 32'h0, S_IDLE}) begin
            $display("FAIL reset_values: got req=%0b valid=%0b err=%0b pc=%02h instr=%08h state=%0d",
                     imem_req_o, instr_valid_o, fetch_err_o, pc_o, instr_o, dbg_state_o);
        end else pass_cnt++;
        arst_ni = 1'b1;
        @(negedge clk_i);
        // First cycle after release: idle, the stray ack was ignored.
        chk_cnt++;
        if ({dbg_state_o, instr_o} !== {S_REQ, 32'h0}) begin
            $display("FAIL idle_to_req: got state=%0d instr=%08h, expected state=%0d instr=0",
                     dbg_state_o, instr_o, S_REQ);
        end else pass_cnt++;
        imem_ack_i = 1'b0;
        exp_pc = BOOT;
    endtask

    task automatic test_zero_wait;
        do_fetch(0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_ack_latency;
        for (int k = 0; k < 3; k++) do_fetch(3, 0, 1'b1, 1'b0);
    endtask

    task automatic test_stall;
        do_fetch($urandom_range(0, 2), 5, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        walk_to(8'hFF);
        do_fetch(1, 0, 1'b1, 1'b0);
        chk_cnt++;
        if (imem_addr_o !== 8'h00) begin
            $display("FAIL wrap_addr: got %02h, expected 00", imem_addr_o);
        end else pass_cnt++;
    endtask

    task automatic test_invalid_pc;
        walk_to(8'h05);
        do_fetch(0, 1, 1'b0, 1'b0);
        chk_cnt++;
        if (imem_addr_o !== BOOT) begin
            $display("FAIL reboot_addr: got %02h, expected %02h", imem_addr_o, BOOT);
        end else pass_cnt++;
    endtask

    task automatic test_random;
        for (int k = 0; k < 30; k++)
            do_fetch($urandom_range(0, 4), $urandom_range(0, 3),
                     ($urandom_range(0, 4) != 0), 1'b0);
    endtask

    task automatic test_reset_mid_request;
        walk_to(BOOT + 8'd3);
        @(negedge clk_i);
        #2 arst_ni = 1'b0;
        #1;
        chk_cnt++;
        if ({imem_req_o, instr_valid_o, fetch_err_o, pc_o, instr_o} !==
            {1'b0, 1'b0, 1'b0, BOOT, 32'h0}) begin
            $display("FAIL reset_mid_req: got req=%0b valid=%0b err=%0b pc=%02h instr=%08h",
                     imem_req_o, instr_valid_o, fetch_err_o, pc_o, instr_o);
        end else pass_cnt++;
        imem_ack_i = 1'b1;
        imem_rdata_i = $urandom();
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(negedge clk_i);
        chk_cnt++;
        if ({dbg_state_o, instr_o} !== {S_REQ, 32'h0}) begin
            $display("FAIL late_ack_ignored: got state=%0d instr=%08h, expected state=%0d instr=0",
                     dbg_state_o, instr_o, S_REQ);
        end else pass_cnt++;
        imem_ack_i = 1'b0;
        exp_pc = BOOT;
        do_fetch(1, 0, 1'b1, 1'b0);
    endtask

`ifdef INS_FETCH_TIMEOUT_EN
    task automatic test_timeout;
        walk_to(8'h10);
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if ({imem_req_o, fetch_err_o, imem_addr_o} !== {1'b1, 1'b0, 8'h10}) begin
                $display("FAIL timeout_wait: got req=%0b err=%0b addr=%02h, expected req=1 err=0 addr=10",
                         imem_req_o, fetch_err_o, imem_addr_o);
            end else pass_cnt++;
            imem_ack_i = 1'b0;
            @(negedge clk_i);
        end
        exp_pc = BOOT;
        do_fetch(0, 0, 1'b1, 1'b1);
        do_fetch(3, 0, 1'b1, 1'b0);
        do_fetch(0, 0, 1'b1, 1'b0);
    endtask
`else
    task automatic test_long_wait;
        do_fetch(20, 0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        chk_cnt = 0;
        pass_cnt = 0;
        exp_pc = BOOT;
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        test_reset;
        test_zero_wait;
        test_ack_latency;
        test_stall;
        test_wrap;
        test_invalid_pc;
        test_random;
        test_reset_mid_request;
`ifdef INS_FETCH_TIMEOUT_EN
        test_timeout;
`else
        test_long_wait;
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_ins_fetch

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder.
- Holds the program counter and issues single-outstanding requests to IMEM.
- Captures each returned instruction word and presents it to the decoder with a valid/ready handshake.
- Uses the decoder's valid_pc feedback to choose between PC+1 and the boot address.

Parameters:
ADDR_WIDTH, 8, IMEM word-address width; the PC is word-addressed.
BOOT_ADDR, '0, PC value after reset and after an invalid instruction.
TIMEOUT_CYCLES, 16, maximum cycles to wait for imem_ack_i. Used only when INS_FETCH_TIMEOUT_EN is defined.

Ports:
clk_i  input  1  system clock, rising edge.
arst_ni  input  1  asynchronous active-low reset.
imem_req_o  output  1  IMEM read request.
imem_addr_o  output  ADDR_WIDTH  IMEM word address; equals pc_o.
imem_rdata_i  input  INSTR_WIDTH  IMEM read data; sampled only when imem_ack_i=1 in S_REQ.
imem_ack_i  input  1  IMEM read-data valid.
instr_o  output  INSTR_WIDTH  registered instruction; connects to the decoder's imem_rdata_i.
instr_valid_o  output  1  instr_o valid; connects to the decoder's imem_ack_i.
instr_ready_i  input  1  downstream accepts instr_o.
valid_pc_i  input  1  decoder verdict on instr_o: 1 = advance, 0 = reboot.
pc_o  output  ADDR_WIDTH  current PC.
fetch_err_o  output  1  one-cycle timeout pulse. Tied to 0 when the optional feature is off.

Behaviour:
- Reset (async assert, sync deassert by clk_i) sets:
  - state=S_IDLE, pc_o=BOOT_ADDR, instr_o='0.
  - instr_valid_o=0, imem_req_o=0, fetch_err_o=0.
- FSM, state type fetch_state_t:
  - S_IDLE: outputs idle. Next cycle go to S_REQ unconditionally. Occurs only once after reset.
  - S_REQ: imem_req_o=1, imem_addr_o=pc_o.
    - imem_req_o stays high until imem_ack_i=1.
    - On the ack edge: instr_o<=imem_rdata_i, go to S_VALID.
    - Ack may arrive in the same cycle the request is raised (zero wait states).
  - S_VALID: instr_valid_o=1, imem_req_o=0.
    - instr_o is held stable while instr_ready_i=0 (stall of unbounded length).
    - On instr_ready_i=1: pc_o <= valid_pc_i ? pc_o+1 : BOOT_ADDR, then go to S_REQ.
- PC arithmetic: unsigned, modulo 2^ADDR_WIDTH. The all-ones address wraps to 0.
- valid_pc_i is sampled only at the S_VALID accept edge and ignored otherwise.
- imem_ack_i outside S_REQ is ignored; no capture, no state change.
- Throughput: at most one instruction per 2 cycles. Latency from request to instr_valid_o is 1 cycle plus IMEM wait states.
- Reset mid-request: the request is dropped immediately. The PC returns to BOOT_ADDR and a late ack is ignored.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

Optional Feature:
INS_FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) counts cycles spent in S_REQ without an ack.
  - When the count reaches TIMEOUT_CYCLES: fetch_err_o pulses 1 for one cycle, pc_o<=BOOT_ADDR, and the FSM re-enters S_REQ with the counter cleared.
  - The counter clears on ack and on leaving S_REQ.
  - An ack arriving in the timeout cycle wins: it is captured normally and no error is raised.
- Not defined: no counter logic; fetch_err_o tied to 0; S_REQ waits indefinitely.

Decomposition:
- simple_processor_pkg gains:
  - ADDR_WIDTH default constant.
  - BOOT_ADDR constant.
  - fetch_state_t enum {S_IDLE, S_REQ, S_VALID}.
- INSTR_WIDTH comes from the package.
- One natural sub-module, pc_reg: the PC register with increment, boot-load and wrap.
- The FSM and capture register stay in ins_fetch.

Test Plan:
- Reset release, ack tied 1 → cycle 1 S_IDLE, cycle 2 imem_req_o=1 with addr=BOOT_ADDR, cycle 3 instr_valid_o=1 with instr_o equal to the IMEM word.
- Ack latency 3 cycles, instr_ready_i=1, valid_pc_i=1 → imem_req_o held high for 4 cycles; next fetch address is BOOT_ADDR+1, then +2, +3 over three fetches.
- instr_ready_i=0 for 5 cycles in S_VALID → instr_o and instr_valid_o stable, imem_req_o=0, pc_o unchanged; accept on cycle 6.
- valid_pc_i=0 at accept with pc=0x05 → next imem_addr_o=BOOT_ADDR.
- pc=0xFF (ADDR_WIDTH=8), valid_pc_i=1, accept → next imem_addr_o=0x00. Separately, assert arst_ni low during S_REQ → outputs go to reset values and a subsequent ack is ignored.
- With INS_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted, pc=0x10 → fetch_err_o pulses once after 4 request cycles and the next request goes to BOOT_ADDR. Repeat with the ack in the 4th cycle → instruction captured, no error pulse.
